// File: rtl/lsbuffer_pkg.sv
// Shared load/store buffer definitions: field widths, opcodes, entry layout
// and small opcode decode helpers used by the buffer and its extender.
package lsbuffer_pkg;

   localparam int OP_LEN   = 4;
   localparam int DATA_LEN = 32;
   localparam int ROB_LEN  = 4;
   localparam int LSB_LEN  = 4;

   localparam logic [OP_LEN-1:0] OP_LB  = 4'd1;
   localparam logic [OP_LEN-1:0] OP_LH  = 4'd2;
   localparam logic [OP_LEN-1:0] OP_LW  = 4'd3;
   localparam logic [OP_LEN-1:0] OP_LBU = 4'd4;
   localparam logic [OP_LEN-1:0] OP_LHU = 4'd5;
   localparam logic [OP_LEN-1:0] OP_SB  = 4'd6;
   localparam logic [OP_LEN-1:0] OP_SH  = 4'd7;
   localparam logic [OP_LEN-1:0] OP_SW  = 4'd8;

   // Loads at or above this address hit I/O and must not be speculative.
   localparam logic [31:0] IO_BASE = 32'h0003_0000;

   typedef struct packed {
      logic [OP_LEN-1:0]   op;
      logic [DATA_LEN-1:0] imm;
      logic [ROB_LEN-1:0]  robpos;
      logic                rs1_ok;
      logic [DATA_LEN-1:0] rs1_val;
      logic [ROB_LEN-1:0]  rs1_robpos;
      logic                rs2_ok;
      logic [DATA_LEN-1:0] rs2_val;
      logic [ROB_LEN-1:0]  rs2_robpos;
      logic                committed;
      logic                valid;
   } entry_t;

   function automatic logic is_load(input logic [OP_LEN-1:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic [1:0] op_len(input logic [OP_LEN-1:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 2'd0;
         OP_LH, OP_LHU, OP_SH: return 2'd1;
         default:              return 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/lsb_extend.sv
// Combinational byte/half extension of load data; word loads pass through.
module lsb_extend
   import lsbuffer_pkg::*;
(
   input  logic [OP_LEN-1:0]   op,
   input  logic [31:0]         rdata,
   output logic [DATA_LEN-1:0] val
);

   always_comb begin
      case (op)
         OP_LB:   val = {{24{rdata[7]}}, rdata[7:0]};
         OP_LH:   val = {{16{rdata[15]}}, rdata[15:0]};
         OP_LBU:  val = {24'd0, rdata[7:0]};
         OP_LHU:  val = {16'd0, rdata[15:0]};
         default: val = rdata;
      endcase
   end

endmodule

// File: rtl/lsbuffer.sv
// In-order load/store buffer: circular queue with operand wakeup, store commit,
// mispredict flush and a single outstanding memory access issued from the head.
module lsbuffer
   import lsbuffer_pkg::*;
#(
   parameter int LSB_SIZE = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ready,
   input  logic                clear,
   input  logic                push,
   input  logic [OP_LEN-1:0]   push_op,
   input  logic [DATA_LEN-1:0] push_imm,
   input  logic [ROB_LEN-1:0]  push_robpos,
   input  logic                push_rs1_ok,
   input  logic [DATA_LEN-1:0] push_rs1_val,
   input  logic [ROB_LEN-1:0]  push_rs1_robpos,
   input  logic                push_rs2_ok,
   input  logic [DATA_LEN-1:0] push_rs2_val,
   input  logic [ROB_LEN-1:0]  push_rs2_robpos,
   output logic                lsb_full,
   output logic [LSB_LEN-1:0]  lsb_avail_pos,
   input  logic                alu_flag,
   input  logic [DATA_LEN-1:0] alu_val,
   input  logic [ROB_LEN-1:0]  alu_robpos,
   input  logic                rob_store_flag,
   input  logic [LSB_LEN-1:0]  rob_store_lsbpos,
   input  logic [ROB_LEN-1:0]  rob_head,
   output logic                lsb_out_flag,
   output logic [DATA_LEN-1:0] lsb_val,
   output logic [ROB_LEN-1:0]  lsb_robpos,
   output logic                mem_req,
   output logic                mem_wr,
   output logic [31:0]         mem_addr,
   output logic [31:0]         mem_wdata,
   output logic [1:0]          mem_len,
   input  logic                mem_done,
   input  logic [31:0]         mem_rdata
);

   localparam logic [LSB_LEN:0] DEPTH = (LSB_LEN+1)'(LSB_SIZE);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t               state_reg, state_next;
   logic [LSB_LEN-1:0]   head_reg, tail_reg;
   logic [LSB_LEN:0]     count_reg, flush_count;
   logic                 discard_reg;
   entry_t               entry_view [LSB_SIZE];
   logic [LSB_SIZE-1:0]  keep;
   logic                 flush, push_ok, pop, issue, complete, broadcast;
   logic                 head_ready, head_load, alu_wake;
   logic [OP_LEN-1:0]    head_op;
   logic [DATA_LEN-1:0]  issue_addr, ext_val;

   assign flush         = ready & clear;
   assign push_ok       = ready & push & ~clear & (count_reg != DEPTH);
   assign alu_wake      = ready & alu_flag;
   assign head_op       = entry_view[head_reg].op;
   assign head_load     = is_load(head_op);
   assign issue_addr    = entry_view[head_reg].rs1_val + entry_view[head_reg].imm;
   assign pop           = complete & ~discard_reg;
   assign broadcast     = pop & head_load & ~flush;
   assign lsb_full      = count_reg >= (DEPTH - 1'b1);
   assign lsb_avail_pos = tail_reg;

   // Committed entries always form a prefix from head, so a flush keeps exactly those.
   assign flush_count = (LSB_LEN+1)'($countones(keep))
                      - (LSB_LEN+1)'(pop & entry_view[head_reg].committed);

   lsb_extend u_extend (
      .op    (head_op),
      .rdata (mem_rdata),
      .val   (ext_val)
   );

   for (genvar gi = 0; gi < LSB_SIZE; gi++) begin : g_entry
      localparam logic [LSB_LEN-1:0] IDX = LSB_LEN'(gi);
      entry_t entry_reg, entry_next;
      logic   commit_here;

      assign commit_here    = ready & rob_store_flag & (rob_store_lsbpos == IDX);
      assign keep[gi]       = entry_reg.valid & (entry_reg.committed | commit_here);
      assign entry_view[gi] = entry_reg;

      always_comb begin
         entry_next = entry_reg;
         if (push_ok && tail_reg == IDX) begin
            entry_next.op         = push_op;
            entry_next.imm        = push_imm;
            entry_next.robpos     = push_robpos;
            entry_next.rs1_ok     = push_rs1_ok;
            entry_next.rs1_val    = push_rs1_val;
            entry_next.rs1_robpos = push_rs1_robpos;
            entry_next.rs2_ok     = push_rs2_ok;
            entry_next.rs2_val    = push_rs2_val;
            entry_next.rs2_robpos = push_rs2_robpos;
            entry_next.committed  = 1'b0;
            entry_next.valid      = 1'b1;
         end
         if (entry_next.valid && !entry_next.rs1_ok) begin
            if (alu_wake && entry_next.rs1_robpos == alu_robpos) begin
               entry_next.rs1_ok  = 1'b1;
               entry_next.rs1_val = alu_val;
            end else if (lsb_out_flag && entry_next.rs1_robpos == lsb_robpos) begin
               entry_next.rs1_ok  = 1'b1;
               entry_next.rs1_val = lsb_val;
            end
         end
         if (entry_next.valid && !entry_next.rs2_ok) begin
            if (alu_wake && entry_next.rs2_robpos == alu_robpos) begin
               entry_next.rs2_ok  = 1'b1;
               entry_next.rs2_val = alu_val;
            end else if (lsb_out_flag && entry_next.rs2_robpos == lsb_robpos) begin
               entry_next.rs2_ok  = 1'b1;
               entry_next.rs2_val = lsb_val;
            end
         end
         if (commit_here) entry_next.committed = 1'b1;
         if (pop && head_reg == IDX) begin
            entry_next.valid     = 1'b0;
            entry_next.committed = 1'b0;
         end
         if (flush && !entry_next.committed) entry_next.valid = 1'b0;
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) entry_reg <= '0;
         else       entry_reg <= entry_next;
      end
   end

   always_comb begin
      head_ready = 1'b0;
      if (count_reg != '0) begin
         if (head_load)
            head_ready = entry_view[head_reg].rs1_ok &&
                         (issue_addr < IO_BASE || entry_view[head_reg].robpos == rob_head);
         else
            head_ready = entry_view[head_reg].rs1_ok && entry_view[head_reg].rs2_ok &&
                         entry_view[head_reg].committed;
      end
   end

   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      complete   = 1'b0;
      case (state_reg)
         IDLE: if (ready && !clear && head_ready) begin
            issue      = 1'b1;
            state_next = WAIT_MEM;
         end
         WAIT_MEM: if (mem_done) begin
            complete   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         discard_reg  <= 1'b0;
         mem_req      <= 1'b0;
         mem_wr       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_len      <= '0;
         lsb_out_flag <= 1'b0;
         lsb_val      <= '0;
         lsb_robpos   <= '0;
      end else begin
         state_reg    <= state_next;
         mem_req      <= issue;
         lsb_out_flag <= broadcast;
         if (issue) begin
            mem_wr    <= ~head_load;
            mem_addr  <= issue_addr;
            mem_len   <= op_len(head_op);
            mem_wdata <= head_load ? '0 : entry_view[head_reg].rs2_val;
         end
         if (broadcast) begin
            lsb_val    <= ext_val;
            lsb_robpos <= entry_view[head_reg].robpos;
         end
         // A flushed in-flight load is already gone from the queue; only its response remains.
         if (complete)
            discard_reg <= 1'b0;
         else if (flush && state_reg == WAIT_MEM && head_load)
            discard_reg <= 1'b1;
         if (flush) begin
            head_reg  <= head_reg + LSB_LEN'(pop);
            count_reg <= flush_count;
            tail_reg  <= head_reg + LSB_LEN'(pop) + flush_count[LSB_LEN-1:0];
         end else begin
            head_reg  <= head_reg + LSB_LEN'(pop);
            tail_reg  <= tail_reg + LSB_LEN'(push_ok);
            count_reg <= count_reg + (LSB_LEN+1)'(push_ok) - (LSB_LEN+1)'(pop);
         end
      end
   end

endmodule

// File: tb/tb_lsbuffer.sv
// Directed bench for lsbuffer: a responder models memory, one line per request/broadcast.
module tb_lsbuffer;
   import lsbuffer_pkg::*;

   logic                clk = 1'b0;
   logic                reset, ready, clear, push;
   logic [OP_LEN-1:0]   push_op;
   logic [DATA_LEN-1:0] push_imm, push_rs1_val, push_rs2_val;
   logic [ROB_LEN-1:0]  push_robpos, push_rs1_robpos, push_rs2_robpos;
   logic                push_rs1_ok, push_rs2_ok;
   logic                lsb_full;
   logic [LSB_LEN-1:0]  lsb_avail_pos;
   logic                alu_flag;
   logic [DATA_LEN-1:0] alu_val;
   logic [ROB_LEN-1:0]  alu_robpos;
   logic                rob_store_flag;
   logic [LSB_LEN-1:0]  rob_store_lsbpos;
   logic [ROB_LEN-1:0]  rob_head;
   logic                lsb_out_flag;
   logic [DATA_LEN-1:0] lsb_val;
   logic [ROB_LEN-1:0]  lsb_robpos;
   logic                mem_req, mem_wr;
   logic [31:0]         mem_addr, mem_wdata;
   logic [1:0]          mem_len;
   logic                mem_done = 1'b0;
   logic [31:0]         mem_rdata = 32'd0;

   int          total = 0, passed = 0;
   int          req_count = 0, bc_count = 0;
   logic [31:0] last_addr = 0, last_wdata = 0, last_bc_val = 0;
   logic        last_wr = 0;
   logic [1:0]  last_len = 0;
   logic [ROB_LEN-1:0] last_bc_robpos = 0;
   logic        pending = 1'b0, resp_enable = 1'b1;
   logic [31:0] resp_data = 32'd0;

   always #5 clk = ~clk;

   lsbuffer #(.LSB_SIZE(16)) dut (
      .clk(clk), .reset(reset), .ready(ready), .clear(clear), .push(push),
      .push_op(push_op), .push_imm(push_imm), .push_robpos(push_robpos),
      .push_rs1_ok(push_rs1_ok), .push_rs1_val(push_rs1_val), .push_rs1_robpos(push_rs1_robpos),
      .push_rs2_ok(push_rs2_ok), .push_rs2_val(push_rs2_val), .push_rs2_robpos(push_rs2_robpos),
      .lsb_full(lsb_full), .lsb_avail_pos(lsb_avail_pos),
      .alu_flag(alu_flag), .alu_val(alu_val), .alu_robpos(alu_robpos),
      .rob_store_flag(rob_store_flag), .rob_store_lsbpos(rob_store_lsbpos), .rob_head(rob_head),
      .lsb_out_flag(lsb_out_flag), .lsb_val(lsb_val), .lsb_robpos(lsb_robpos),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_len(mem_len), .mem_done(mem_done), .mem_rdata(mem_rdata)
   );

   // Memory responder and transaction log; answers one cycle after the request when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mem_done) mem_done = 1'b0;
         if (mem_req) begin
            req_count++;
            last_addr  = mem_addr;
            last_wr    = mem_wr;
            last_len   = mem_len;
            last_wdata = mem_wdata;
            pending    = 1'b1;
            $display("%0t req addr=%08h wr=%0d len=%0d wdata=%08h", $time, mem_addr, mem_wr, mem_len, mem_wdata);
         end
         if (lsb_out_flag) begin
            bc_count++;
            last_bc_val    = lsb_val;
            last_bc_robpos = lsb_robpos;
            $display("%0t load result val=%08h robpos=%0d", $time, lsb_val, lsb_robpos);
         end
         if (pending && resp_enable) begin
            mem_done  = 1'b1;
            mem_rdata = resp_data;
            pending   = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_push(input logic [OP_LEN-1:0] op, input logic [31:0] imm,
                          input logic [ROB_LEN-1:0] robpos, input logic r1ok,
                          input logic [31:0] r1val, input logic [ROB_LEN-1:0] r1tag,
                          input logic r2ok, input logic [31:0] r2val);
      push            = 1'b1;
      push_op         = op;
      push_imm        = imm;
      push_robpos     = robpos;
      push_rs1_ok     = r1ok;
      push_rs1_val    = r1val;
      push_rs1_robpos = r1tag;
      push_rs2_ok     = r2ok;
      push_rs2_val    = r2val;
      push_rs2_robpos = '0;
      @(negedge clk);
      push = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ready = 1'b1; clear = 1'b0; push = 1'b0;
      push_op = '0; push_imm = '0; push_robpos = '0;
      push_rs1_ok = 1'b0; push_rs1_val = '0; push_rs1_robpos = '0;
      push_rs2_ok = 1'b0; push_rs2_val = '0; push_rs2_robpos = '0;
      alu_flag = 1'b0; alu_val = '0; alu_robpos = '0;
      rob_store_flag = 1'b0; rob_store_lsbpos = '0; rob_head = '0;
      cycles(2);
      reset = 1'b0;
      check("rst_mem_req", mem_req, 0);
      check("rst_out_flag", lsb_out_flag, 0);
      check("rst_full", lsb_full, 0);
      check("rst_avail", lsb_avail_pos, 0);
      check("rst_mem_addr", mem_addr, 0);

      // LB sign extension
      resp_data = 32'h0000_0080;
      do_push(OP_LB, 32'd3, 4'd1, 1'b1, 32'h100, 4'd0, 1'b0, 32'd0);
      cycles(5);
      check("lb_req_count", req_count, 1);
      check("lb_addr", last_addr, 32'h103);
      check("lb_len", last_len, 0);
      check("lb_wr", last_wr, 0);
      check("lb_bc_count", bc_count, 1);
      check("lb_val", last_bc_val, 32'hFFFF_FF80);
      check("lb_robpos", last_bc_robpos, 1);

      // Store waits for commit
      do_push(OP_SW, 32'd4, 4'd2, 1'b1, 32'h200, 4'd0, 1'b1, 32'hDEAD_BEEF);
      cycles(5);
      check("sw_uncommitted", req_count, 1);
      rob_store_flag = 1'b1; rob_store_lsbpos = 4'd1;
      cycles(1);
      rob_store_flag = 1'b0;
      cycles(5);
      check("sw_req_count", req_count, 2);
      check("sw_wr", last_wr, 1);
      check("sw_wdata", last_wdata, 32'hDEAD_BEEF);
      check("sw_addr", last_addr, 32'h204);
      check("sw_len", last_len, 2);
      check("sw_no_bc", bc_count, 1);

      // Load waiting on ALU tag 5
      resp_data = 32'h0001_8001;
      do_push(OP_LH, 32'd8, 4'd3, 1'b0, 32'd0, 4'd5, 1'b1, 32'd0);
      cycles(4);
      check("lh_pending", req_count, 2);
      alu_flag = 1'b1; alu_robpos = 4'd5; alu_val = 32'h200;
      cycles(1);
      alu_flag = 1'b0;
      cycles(5);
      check("lh_req_count", req_count, 3);
      check("lh_addr", last_addr, 32'h208);
      check("lh_len", last_len, 1);
      check("lh_bc_count", bc_count, 2);
      check("lh_val", last_bc_val, 32'hFFFF_8001);
      check("lh_robpos", last_bc_robpos, 3);

      // I/O load waits for rob_head
      rob_head = 4'd4;
      resp_data = 32'hCAFE_F00D;
      do_push(OP_LW, 32'd0, 4'd7, 1'b1, 32'h0003_0000, 4'd0, 1'b1, 32'd0);
      cycles(6);
      check("io_blocked", req_count, 3);
      rob_head = 4'd7;
      cycles(5);
      check("io_req_count", req_count, 4);
      check("io_addr", last_addr, 32'h0003_0000);
      check("io_val", last_bc_val, 32'hCAFE_F00D);
      rob_head = 4'd0;

      // Flush with three committed stores and two loads queued
      resp_enable = 1'b0;
      do_push(OP_SB, 32'd0, 4'd8, 1'b1, 32'h1000, 4'd0, 1'b1, 32'h11);
      do_push(OP_SH, 32'd0, 4'd9, 1'b1, 32'h1004, 4'd0, 1'b1, 32'h22);
      do_push(OP_SW, 32'd0, 4'd10, 1'b1, 32'h1008, 4'd0, 1'b1, 32'h33);
      do_push(OP_LW, 32'd0, 4'd11, 1'b0, 32'd0, 4'd14, 1'b1, 32'd0);
      do_push(OP_LW, 32'd0, 4'd12, 1'b0, 32'd0, 4'd14, 1'b1, 32'd0);
      for (int i = 4; i < 7; i++) begin
         rob_store_flag = 1'b1; rob_store_lsbpos = LSB_LEN'(i);
         cycles(1);
      end
      rob_store_flag = 1'b0;
      cycles(2);
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
      check("clr_count", dut.count_reg, 3);
      check("clr_tail", lsb_avail_pos, 7);
      check("clr_s0_issued", req_count, 5);
      alu_flag = 1'b1; alu_robpos = 4'd14; alu_val = 32'h500;
      cycles(1);
      alu_flag = 1'b0;
      resp_enable = 1'b1;
      cycles(15);
      check("clr_drain_reqs", req_count, 7);
      check("clr_no_bc", bc_count, 3);
      check("clr_drained", dut.count_reg, 0);
      check("clr_last_addr", last_addr, 32'h1008);

      // Flush while a load is in flight
      resp_enable = 1'b0;
      do_push(OP_LW, 32'd0, 4'd13, 1'b1, 32'h80, 4'd0, 1'b1, 32'd0);
      cycles(3);
      check("fl_issued", req_count, 8);
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
      cycles(2);
      check("fl_tail", lsb_avail_pos, 7);
      resp_enable = 1'b1;
      cycles(4);
      check("fl_no_bc", bc_count, 3);
      check("fl_count", dut.count_reg, 0);
      resp_data = 32'h1234_56AB;
      do_push(OP_LBU, 32'hFFFF_FFFF, 4'd2, 1'b1, 32'h10, 4'd0, 1'b1, 32'd0);
      cycles(5);
      check("lbu_req_count", req_count, 9);
      check("lbu_addr", last_addr, 32'h0000_000F);
      check("lbu_bc_count", bc_count, 4);
      check("lbu_val", last_bc_val, 32'h0000_00AB);

      // Fill to capacity, overflow, drain and wrap
      for (int i = 0; i < 14; i++)
         do_push(OP_LW, 32'd0, 4'd6, 1'b0, 32'd0, 4'd15, 1'b1, 32'd0);
      check("full_at_14", lsb_full, 0);
      do_push(OP_LW, 32'd0, 4'd6, 1'b0, 32'd0, 4'd15, 1'b1, 32'd0);
      check("full_at_15", lsb_full, 1);
      do_push(OP_LW, 32'd0, 4'd6, 1'b0, 32'd0, 4'd15, 1'b1, 32'd0);
      check("count_16", dut.count_reg, 16);
      do_push(OP_LW, 32'd0, 4'd6, 1'b0, 32'd0, 4'd15, 1'b1, 32'd0);
      check("ovf_count", dut.count_reg, 16);
      check("ovf_tail", lsb_avail_pos, 8);
      alu_flag = 1'b1; alu_robpos = 4'd15; alu_val = 32'h40;
      cycles(1);
      alu_flag = 1'b0;
      cycles(50);
      check("drain_reqs", req_count, 25);
      check("drain_bcs", bc_count, 20);
      check("drain_count", dut.count_reg, 0);
      check("drain_tail", lsb_avail_pos, 8);
      check("drain_full", lsb_full, 0);
      alu_flag = 1'b1; alu_robpos = 4'd9; alu_val = 32'h60;
      do_push(OP_LW, 32'd4, 4'd6, 1'b0, 32'd0, 4'd9, 1'b1, 32'd0);
      alu_flag = 1'b0;
      cycles(5);
      check("pushwake_req", req_count, 26);
      check("pushwake_addr", last_addr, 32'h64);
      check("pushwake_bc", bc_count, 21);
      check("pushwake_tail", lsb_avail_pos, 9);

      // Not ready: push ignored
      ready = 1'b0;
      do_push(OP_LW, 32'd0, 4'd1, 1'b1, 32'h70, 4'd0, 1'b1, 32'd0);
      cycles(3);
      check("hold_count", dut.count_reg, 0);
      check("hold_req", req_count, 26);
      ready = 1'b1;

      // Reset mid-access, late mem_done ignored
      resp_enable = 1'b0;
      do_push(OP_LW, 32'd0, 4'd3, 1'b1, 32'h50, 4'd0, 1'b1, 32'd0);
      cycles(3);
      check("rmo_issued", req_count, 27);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      check("rmo_mem_req", mem_req, 0);
      check("rmo_avail", lsb_avail_pos, 0);
      resp_enable = 1'b1;
      cycles(5);
      check("rmo_no_bc", bc_count, 21);
      check("rmo_count", dut.count_reg, 0);
      check("rmo_no_req", req_count, 27);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
